// File: rtl/simmem_delay_releaser.sv
// Per-slot delay timers that raise release_en for a bank slot after its delay and hold it until released.
// Optional SIMMEM_RELEASER_ERR_CHECK_EN builds the sticky protocol checker behind err_o.
module simmem_delay_releaser #(
  parameter int unsigned NumSlots = 32,
  parameter int unsigned IidW     = $clog2(NumSlots),
  parameter int unsigned DelayW   = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IidW-1:0]     iid_i,
  input  logic [DelayW-1:0]   delay_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [NumSlots-1:0] release_en_o,
  input  logic [NumSlots-1:0] released_onehot_i,
  output logic [IidW:0]       occupancy_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    COUNTING = 2'd1,
    EXPIRED  = 2'd2
  } slot_state_e;

  slot_state_e       state_q [NumSlots];
  logic [DelayW-1:0] cnt_q   [NumSlots];

  logic [NumSlots-1:0] expired;
  logic [NumSlots-1:0] rel_valid;
  logic [IidW:0]       rel_cnt;
  logic                arm;

  always_comb begin
    expired = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      expired[i] = (state_q[i] == EXPIRED);
    end
  end

  assign release_en_o = expired;
  assign in_ready_o   = (state_q[iid_i] == FREE);
  assign arm          = in_valid_i && in_ready_o;
  // Release bits for slots that are not EXPIRED are dropped here.
  assign rel_valid    = released_onehot_i & expired;

  always_comb begin
    rel_cnt = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      rel_cnt = rel_cnt + (IidW+1)'(rel_valid[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        state_q[i] <= FREE;
        cnt_q[i]   <= '0;
      end
      occupancy_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        unique case (state_q[i])
          FREE: begin
            if (arm && (iid_i == IidW'(i))) begin
              if (delay_i <= DelayW'(1)) begin
                state_q[i] <= EXPIRED;
              end else begin
                state_q[i] <= COUNTING;
                cnt_q[i]   <= delay_i - DelayW'(1);
              end
            end
          end
          COUNTING: begin
            if (cnt_q[i] == DelayW'(1)) begin
              state_q[i] <= EXPIRED;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] - DelayW'(1);
            end
          end
          EXPIRED: begin
            if (released_onehot_i[i]) state_q[i] <= FREE;
          end
          default: state_q[i] <= FREE;
        endcase
      end
      occupancy_o <= occupancy_o + (IidW+1)'(arm) - rel_cnt;
    end
  end

`ifdef SIMMEM_RELEASER_ERR_CHECK_EN
  localparam int unsigned WdW = $clog2(NumSlots) + DelayW + 2;
  localparam logic [WdW-1:0] WdLimit = WdW'(NumSlots) << DelayW;

  logic [WdW-1:0] wd_q;
  logic           err_q;
  logic           bad_rel;
  logic           not_onehot;
  logic           stall;

  assign bad_rel    = |(released_onehot_i & ~expired);
  assign not_onehot = |(released_onehot_i & (released_onehot_i - NumSlots'(1)));
  assign stall      = in_valid_i && !in_ready_o;

  // wd_q counts consecutive stalled cycles; saturates so it cannot wrap back below the limit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!stall)         wd_q <= '0;
      else if (wd_q != '1) wd_q <= wd_q + WdW'(1);
      if (bad_rel || not_onehot || (stall && (wd_q >= WdLimit))) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
